// File: rtl/pwm_capture_monitor.sv
// Purpose: PWM pair capture (period, high time, dead-time) plus sticky shoot-through detection, Wishbone slave.
// Latency: measurements lag pwm_in by 2 cycles (2+FILTER_LEN with PWM_MON_GLITCH_FILTER_EN); wb_ack 1 cycle after wb_stb.
// Backpressure: none; every access is acked in one cycle, and ack drops for a cycle before the next access.
module pwm_capture_monitor #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic                  wb_stb,
  output logic                  wb_ack,
  input  logic [7:0]            pwm_in,
  output logic                  shoot_irq
);

  typedef enum logic [1:0] {DISARMED, ARMED, MEASURING} st_t;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [7:0] sync1, sync2, pwm_s, pwm_d, rise, fall;
  logic       enable, clear_q;
  logic [3:0] irq_mask, sticky, new_smp, publish, shoot_now;
  logic [3:0] dead_start_hi, dead_start_lo, dead_other_rise, dead_same_rise;
  logic [3:0] dead_run, dead_src;
  st_t        st_q [4];
  st_t        st_nxt [4];
  logic [CNT_WIDTH-1:0] per_cnt [4], hi_cnt [4], hi_shadow [4], dead_cnt [4];
  logic [CNT_WIDTH-1:0] pub_per [4], pub_hi [4], min_dead [4], last_dead [4];
  logic        acc, wr_ctrl, wr_stat;
  logic [31:0] rdata;
  logic [31:0] unused_bits;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer for the asynchronous PWM bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_MON_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt [8];
  logic [7:0]    flt_q;

  // Each bit follows its input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q <= '0;
      for (int i = 0; i < 8; i++) flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == flt_q[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
          flt_q[i]   <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign pwm_s = flt_q;
  assign unused_bits = {wb_dat_i[31:8], 4'd0, wb_sel};
`else
  assign pwm_s = sync2;
  assign unused_bits = {wb_dat_i[31:8], 4'd0, wb_sel} ^ 32'(FILTER_LEN);
`endif

  // Previous-cycle copy of the observed bus for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_d <= '0;
    else        pwm_d <= pwm_s;
  end

  assign rise      = pwm_s & ~pwm_d;
  assign fall      = ~pwm_s & pwm_d;
  assign acc       = wb_stb & ~wb_ack;
  assign wr_ctrl   = acc & wb_we & (wb_addr == ADDR_WIDTH'(8'h00));
  assign wr_stat   = acc & wb_we & (wb_addr == ADDR_WIDTH'(8'h04));
  assign shoot_irq = |(sticky & ~irq_mask);

  // Per-pair FSM state register; clear and disable force every pair back to DISARMED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) st_q[k] <= DISARMED;
    end else begin
      for (int k = 0; k < 4; k++) st_q[k] <= (clear_q || !enable) ? DISARMED : st_nxt[k];
    end
  end

  // Per-pair next state: advance on high-side rising edges
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      st_nxt[k] = st_q[k];
      case (st_q[k])
        DISARMED: if (rise[2*k]) st_nxt[k] = ARMED;
        ARMED:    if (rise[2*k]) st_nxt[k] = MEASURING;
        default:  st_nxt[k] = MEASURING;
      endcase
    end
  end

  // Per-pair outputs: publish strobe, shoot-through and dead-time edge qualifiers
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      publish[k]         = enable & rise[2*k] & (st_q[k] == MEASURING);
      shoot_now[k]       = pwm_s[2*k] & pwm_s[2*k+1];
      dead_start_hi[k]   = fall[2*k] & ~pwm_s[2*k+1];
      dead_start_lo[k]   = fall[2*k+1] & ~pwm_s[2*k];
      dead_other_rise[k] = dead_src[k] ? rise[2*k] : rise[2*k+1];
      dead_same_rise[k]  = dead_src[k] ? rise[2*k+1] : rise[2*k];
    end
  end

  // Control register; clear is a one-cycle pulse acted on by the measurement logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      clear_q  <= 1'b0;
      irq_mask <= '0;
    end else begin
      clear_q <= wr_ctrl & wb_dat_i[1];
      if (wr_ctrl) begin
        enable   <= wb_dat_i[0];
        irq_mask <= wb_dat_i[7:4];
      end
    end
  end

  // Measurement counters, published registers and sticky flags (clear beats hardware, hardware beats W1C)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0; new_smp <= '0; dead_run <= '0; dead_src <= '0;
      for (int k = 0; k < 4; k++) begin
        per_cnt[k] <= '0; hi_cnt[k] <= '0; hi_shadow[k] <= '0; dead_cnt[k] <= '0;
        pub_per[k] <= '0; pub_hi[k] <= '0; min_dead[k] <= '0; last_dead[k] <= '0;
      end
    end else if (clear_q) begin
      sticky <= '0; new_smp <= '0; dead_run <= '0; dead_src <= '0;
      for (int k = 0; k < 4; k++) begin
        per_cnt[k] <= '0; hi_cnt[k] <= '0; hi_shadow[k] <= '0; dead_cnt[k] <= '0;
        pub_per[k] <= '0; pub_hi[k] <= '0; min_dead[k] <= '0; last_dead[k] <= '0;
      end
    end else begin
      sticky  <= shoot_now | (sticky & ~(wr_stat ? wb_dat_i[3:0] : 4'd0));
      new_smp <= publish | (new_smp & ~(wr_stat ? wb_dat_i[7:4] : 4'd0));
      for (int k = 0; k < 4; k++) begin
        if (!enable) begin
          per_cnt[k] <= '0; hi_cnt[k] <= '0; hi_shadow[k] <= '0; dead_cnt[k] <= '0;
          dead_run[k] <= 1'b0;
        end else begin
          if (rise[2*k])                per_cnt[k] <= CNT_WIDTH'(1);
          else if (st_q[k] != DISARMED) per_cnt[k] <= sat_inc(per_cnt[k]);
          if (rise[2*k])                hi_cnt[k] <= CNT_WIDTH'(1);
          else if (pwm_s[2*k])          hi_cnt[k] <= sat_inc(hi_cnt[k]);
          if (fall[2*k])                hi_shadow[k] <= hi_cnt[k];
          if (publish[k]) begin
            pub_per[k] <= per_cnt[k];
            pub_hi[k]  <= hi_shadow[k];
          end
          if (dead_start_hi[k] || dead_start_lo[k]) begin
            dead_run[k] <= 1'b1;
            dead_src[k] <= dead_start_lo[k] & ~dead_start_hi[k];
            dead_cnt[k] <= CNT_WIDTH'(1);
          end else if (dead_run[k]) begin
            if (dead_other_rise[k]) begin
              last_dead[k] <= dead_cnt[k];
              if (dead_cnt[k] < min_dead[k] || min_dead[k] == '0) min_dead[k] <= dead_cnt[k];
              dead_run[k] <= 1'b0;
            end else if (dead_same_rise[k]) begin
              dead_run[k] <= 1'b0;
            end else begin
              dead_cnt[k] <= sat_inc(dead_cnt[k]);
            end
          end
        end
      end
    end
  end

  // Read-data mux; unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (wb_addr == ADDR_WIDTH'(8'h00)) rdata = {24'd0, irq_mask, 2'b00, clear_q, enable};
    if (wb_addr == ADDR_WIDTH'(8'h04)) rdata = {24'd0, new_smp, sticky};
    for (int k = 0; k < 4; k++) begin
      if (wb_addr == ADDR_WIDTH'(16 + 8*k)) rdata = {16'(pub_per[k]), 16'(pub_hi[k])};
      if (wb_addr == ADDR_WIDTH'(20 + 8*k)) rdata = {16'(last_dead[k]), 16'(min_dead[k])};
    end
  end

  // Registered one-cycle acknowledge with read data valid alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= acc;
      wb_dat_o <= (acc && !wb_we) ? rdata : 32'd0;
    end
  end

endmodule
